// File: rtl/picorv_trace_buf.sv
// ----------------------------------------------------------------------------
// picorv_trace_buf
//   Captures the core's trace words into a first-word-fall-through FIFO.
//   The core is never stalled. A word that arrives while the FIFO is full,
//   with no pop in the same cycle, is dropped and counted in ovf_cnt.
//   The counter saturates at its maximum value. A trap can freeze capture,
//   and only clr or reset leaves the frozen state.
//
// Ports
//   G0_CPU_CLK       sole clock, rising edge
//   G0_CPU_RST_N     asynchronous active-low reset
//   trace_valid      trace word strobe (no backpressure)
//   trace_data       trace word
//   trap             core trap indication (level)
//   cfg_enable       capture enable
//   cfg_stop_on_trap freeze capture on trap
//   clr              one-cycle flush of FIFO, counters and status
//   rd_valid         head word available (fill_level != 0)
//   rd_ready         reader accepts head word
//   rd_data          head word (zero while empty)
//   fill_level       stored word count, 0..DEPTH
//   ovf_cnt          dropped word count, saturating
//   frozen           capture stopped by trap
// ----------------------------------------------------------------------------
module picorv_trace_buf #(
  parameter int DEPTH = 64,
  parameter int TW    = 36,
  parameter int CNT_W = 16
) (
  input  logic                     G0_CPU_CLK,
  input  logic                     G0_CPU_RST_N,
  input  logic                     trace_valid,
  input  logic [TW-1:0]            trace_data,
  input  logic                     trap,
  input  logic                     cfg_enable,
  input  logic                     cfg_stop_on_trap,
  input  logic                     clr,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [TW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [CNT_W-1:0]         ovf_cnt,
  output logic                     frozen
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] OVF_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FROZEN  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [TW-1:0]   mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     fill_r;
  logic [CNT_W-1:0] ovf_r;

  logic push_req_s;
  logic pop_s;
  logic full_s;
  logic push_ok_s;
  logic drop_s;

  // Push/pop qualification. A full FIFO still accepts a word when the head
  // leaves in the same cycle, so the slot frees exactly as it is refilled.
  always_comb begin
    push_req_s = (state_r == ST_CAPTURE) && trace_valid;
    pop_s      = (fill_r != (AW+1)'(0)) && rd_ready;
    full_s     = (fill_r == FULL_LVL);
    push_ok_s  = push_req_s && (!full_s || pop_s);
    drop_s     = push_req_s && full_s && !pop_s;
  end

  // Capture FSM next state. clr takes priority over every transition.
  always_comb begin
    state_nxt_s = state_r;
    if (clr) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cfg_enable) state_nxt_s = ST_CAPTURE;
          else            state_nxt_s = ST_IDLE;
        end
        ST_CAPTURE: begin
          // The trapping cycle's word is still pushed; the freeze follows.
          if (trap && cfg_stop_on_trap) state_nxt_s = ST_FROZEN;
          else if (!cfg_enable)         state_nxt_s = ST_IDLE;
          else                          state_nxt_s = ST_CAPTURE;
        end
        ST_FROZEN: state_nxt_s = ST_FROZEN;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Capture FSM state register.
  always_ff @(posedge G0_CPU_CLK or negedge G0_CPU_RST_N) begin
    if (!G0_CPU_RST_N) state_r <= ST_IDLE;
    else               state_r <= state_nxt_s;
  end

  // FIFO pointers, fill count and saturating overflow counter.
  always_ff @(posedge G0_CPU_CLK or negedge G0_CPU_RST_N) begin
    if (!G0_CPU_RST_N) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      fill_r   <= (AW+1)'(0);
      ovf_r    <= {CNT_W{1'b0}};
    end else if (clr) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      fill_r   <= (AW+1)'(0);
      ovf_r    <= {CNT_W{1'b0}};
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_s})
        2'b10:   fill_r <= fill_r + (AW+1)'(1);
        2'b01:   fill_r <= fill_r - (AW+1)'(1);
        default: fill_r <= fill_r;
      endcase
      if (drop_s && (ovf_r != OVF_MAX)) ovf_r <= ovf_r + CNT_W'(1);
    end
  end

  // Storage array; left unreset since fill_r alone decides what is valid.
  always_ff @(posedge G0_CPU_CLK) begin
    if (push_ok_s && !clr) mem_r[wr_ptr_r] <= trace_data;
  end

  // Outputs are direct views of registered state; rd_data is forced to zero
  // while empty so reset clears it without resetting the array.
  always_comb begin
    rd_valid   = (fill_r != (AW+1)'(0));
    rd_data    = rd_valid ? mem_r[rd_ptr_r] : {TW{1'b0}};
    fill_level = fill_r;
    ovf_cnt    = ovf_r;
    frozen     = (state_r == ST_FROZEN);
  end

endmodule

// File: tb/tb_picorv_trace_buf.sv
module tb_picorv_trace_buf;

  localparam int DEPTH = 64;
  localparam int TW    = 36;
  localparam int CNT_W = 16;
  localparam int FW    = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              trace_valid = 1'b0;
  logic [TW-1:0]     trace_data = '0;
  logic              trap = 1'b0;
  logic              cfg_enable = 1'b0;
  logic              cfg_stop_on_trap = 1'b0;
  logic              clr = 1'b0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [TW-1:0]     rd_data;
  logic [FW-1:0]     fill_level;
  logic [CNT_W-1:0]  ovf_cnt;
  logic              frozen;

  int n_cmp  = 0;
  int n_fail = 0;

  picorv_trace_buf #(.DEPTH(DEPTH), .TW(TW), .CNT_W(CNT_W)) dut (
    .G0_CPU_CLK       (clk),
    .G0_CPU_RST_N     (rst_n),
    .trace_valid      (trace_valid),
    .trace_data       (trace_data),
    .trap             (trap),
    .cfg_enable       (cfg_enable),
    .cfg_stop_on_trap (cfg_stop_on_trap),
    .clr              (clr),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .rd_data          (rd_data),
    .fill_level       (fill_level),
    .ovf_cnt          (ovf_cnt),
    .frozen           (frozen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic          stop;
    logic          trp;
    logic          cl;
    logic          vld;
    logic          rr;
    logic [TW-1:0] data;
    logic          e_rv;
    logic [TW-1:0] e_d;
    logic [FW-1:0] e_fill;
    logic [CNT_W-1:0] e_ovf;
    logic          e_fr;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic en, logic stop, logic trp, logic cl, logic vld,
                              logic rr, logic [TW-1:0] data, logic e_rv,
                              logic [TW-1:0] e_d, logic [FW-1:0] e_fill, logic e_fr);
    vec_t v;
    v.en = en; v.stop = stop; v.trp = trp; v.cl = cl; v.vld = vld; v.rr = rr;
    v.data = data; v.e_rv = e_rv; v.e_d = e_d; v.e_fill = e_fill;
    v.e_ovf = 16'd0; v.e_fr = e_fr;
    return v;
  endfunction

  function automatic logic [TW-1:0] word(int i);
    return 36'h100 + TW'(i);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_rv, input logic [TW-1:0] e_d,
                         input logic [FW-1:0] e_fill, input logic [CNT_W-1:0] e_ovf,
                         input logic e_fr);
    chk({tag, ".rd_valid"},   64'(rd_valid),   64'(e_rv));
    chk({tag, ".rd_data"},    64'(rd_data),    64'(e_d));
    chk({tag, ".fill_level"}, 64'(fill_level), 64'(e_fill));
    chk({tag, ".ovf_cnt"},    64'(ovf_cnt),    64'(e_ovf));
    chk({tag, ".frozen"},     64'(frozen),     64'(e_fr));
  endtask

  task automatic drive(input logic en, input logic stop, input logic trp, input logic cl,
                       input logic vld, input logic rr, input logic [TW-1:0] data);
    cfg_enable = en; cfg_stop_on_trap = stop; trap = trp; clr = cl;
    trace_valid = vld; rd_ready = rr; trace_data = data;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //            en   stop trap clr  vld  rr   data     rv   d        fill fr
    vecs[0]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,36'h0,   1'b0,36'h0,   7'd0,1'b0);
    vecs[1]  = mk(1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,36'h1,   1'b1,36'h1,   7'd1,1'b0);
    vecs[2]  = mk(1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,36'h2,   1'b1,36'h2,   7'd1,1'b0);
    vecs[3]  = mk(1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,36'h3,   1'b1,36'h3,   7'd1,1'b0);
    vecs[4]  = mk(1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,36'h4,   1'b1,36'h4,   7'd1,1'b0);
    vecs[5]  = mk(1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,36'h5,   1'b1,36'h5,   7'd1,1'b0);
    vecs[6]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,36'h0,   1'b0,36'h0,   7'd0,1'b0);
    vecs[7]  = mk(1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,36'h5A,  1'b1,36'h5A,  7'd1,1'b0);
    vecs[8]  = mk(1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,36'hA,   1'b1,36'h5A,  7'd2,1'b1);
    vecs[9]  = mk(1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,36'hB,   1'b1,36'h5A,  7'd2,1'b1);
    vecs[10] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,36'hC,   1'b1,36'hA,   7'd1,1'b1);
    vecs[11] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,36'h0,   1'b0,36'h0,   7'd0,1'b1);
    vecs[12] = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,36'h0,   1'b0,36'h0,   7'd0,1'b0);
    vecs[13] = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,36'h0,   1'b0,36'h0,   7'd0,1'b0);
    vecs[14] = mk(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,36'h11,  1'b1,36'h11,  7'd1,1'b0);
    vecs[15] = mk(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,36'h22,  1'b1,36'h11,  7'd2,1'b0);
    vecs[16] = mk(1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,36'h33,  1'b0,36'h0,   7'd0,1'b0);
    vecs[17] = mk(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,36'h44,  1'b0,36'h0,   7'd0,1'b0);
    vecs[18] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,36'h55,  1'b1,36'h55,  7'd1,1'b0);
    vecs[19] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,36'h66,  1'b0,36'h0,   7'd0,1'b0);

    // Reset state while reset is held
    #2;
    chk_all("reset", 1'b0, 36'h0, 7'd0, 16'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven cycle vectors
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].en, vecs[i].stop, vecs[i].trp, vecs[i].cl, vecs[i].vld,
            vecs[i].rr, vecs[i].data);
      cyc();
      chk_all($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_d, vecs[i].e_fill,
              vecs[i].e_ovf, vecs[i].e_fr);
    end

    // Overflow: 70 pushes into a 64-deep FIFO with no reader
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 36'h0);
    cyc();
    for (int i = 0; i < 70; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, word(i));
      cyc();
    end
    chk_all("ovf70", 1'b1, word(0), 7'd64, 16'd6, 1'b0);

    // Full FIFO, push and pop in the same cycle
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 36'hABC);
    cyc();
    chk_all("fullpp", 1'b1, word(1), 7'd64, 16'd6, 1'b0);

    // Drain: words 1..63 then the word accepted at the tail
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 36'h0);
    for (int i = 1; i < 64; i++) begin
      chk($sformatf("drain%0d", i), 64'(rd_data), 64'(word(i)));
      cyc();
    end
    chk("drain_tail", 64'(rd_data), 64'(36'hABC));
    cyc();
    chk_all("drained", 1'b0, 36'h0, 7'd0, 16'd6, 1'b0);

    // Asynchronous reset with 10 words stored
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 36'h0);
    cyc();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, word(i));
      cyc();
    end
    chk("pre_rst.fill", 64'(fill_level), 64'(7'd10));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 36'h99);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 36'h0, 7'd0, 16'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("release_edge.fill", 64'(fill_level), 64'(7'd0));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 36'h7);
    cyc();
    chk_all("post_rst_push", 1'b1, 36'h7, 7'd1, 16'd0, 1'b0);

    // Overflow counter saturation
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 36'h0);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 36'h0);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 36'h123);
    repeat (64) cyc();
    chk("sat_fill", 64'(fill_level), 64'(7'd64));
    repeat (65534) cyc();
    chk("sat_fffe", 64'(ovf_cnt), 64'(16'hFFFE));
    cyc();
    chk("sat_ffff", 64'(ovf_cnt), 64'(16'hFFFF));
    repeat (3) cyc();
    chk_all("sat_hold", 1'b1, 36'h123, 7'd64, 16'hFFFF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
